// File: rtl/i2s_rx_frame_buffer.sv
// Pairs left/right I2S words into stereo frames and buffers them in a FIFO
// with a valid/ready output and sticky overflow / channel-order error flags.
module i2s_rx_frame_buffer #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [WORD_WIDTH-1:0]   data_i,
    input  logic                    lr_chnl_i,
    input  logic                    write_i,
    output logic [2*WORD_WIDTH-1:0] frame_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [DEPTH_LOG2:0]     level_o,
    output logic                    ovf_o,
    output logic                    desync_o,
    input  logic                    clr_err_i
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic {
        WAIT_L,
        HAVE_L
    } state_t;

    state_t                  state_q;
    logic [WORD_WIDTH-1:0]   left_q;
    logic [DEPTH_LOG2:0]     wr_ptr_q, rd_ptr_q;
    logic                    ovf_q, desync_q;
    logic [2*WORD_WIDTH-1:0] mem_q [DEPTH];

    logic push_req, push_ok, pop, full, empty, ovf_set, desync_set;
    logic [2*WORD_WIDTH-1:0] push_frame;

    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
        pop        = !empty && ready_i;
        push_req   = write_i && lr_chnl_i && (state_q == HAVE_L);
        push_frame = {left_q, data_i};
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok    = push_req && (!full || pop);
        ovf_set    = push_req && full && !pop;
        desync_set = write_i && (((state_q == WAIT_L) &&  lr_chnl_i) ||
                                 ((state_q == HAVE_L) && !lr_chnl_i));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= WAIT_L;
            left_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            desync_q <= 1'b0;
        end else begin
            if (write_i) begin
                unique case (state_q)
                    WAIT_L: begin
                        if (!lr_chnl_i) begin
                            left_q  <= data_i;
                            state_q <= HAVE_L;
                        end
                    end
                    HAVE_L: begin
                        if (!lr_chnl_i) begin
                            left_q <= data_i;
                        end else begin
                            state_q <= WAIT_L;
                        end
                    end
                    default: state_q <= WAIT_L;
                endcase
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Set events take priority over a same-cycle clear.
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (clr_err_i) begin
                ovf_q <= 1'b0;
            end
            if (desync_set) begin
                desync_q <= 1'b1;
            end else if (clr_err_i) begin
                desync_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_frame;
        end
    end

    always_comb begin
        frame_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
        valid_o  = !empty;
        level_o  = wr_ptr_q - rd_ptr_q;
        ovf_o    = ovf_q;
        desync_o = desync_q;
    end

endmodule

// File: doc/i2s_rx_frame_buffer.md
Name: i2s_rx_frame_buffer

Overview:
Sits directly downstream of the I2S receiver top and consumes its data_i, lr_chnl_i and write_i word stream. It pairs each left-channel word with the following right-channel word into one stereo frame. Frames are buffered in a parameterised FIFO and handed to the system side over a valid/ready interface. Channel-ordering faults and overflow are reported as sticky error flags.

Parameters:
WORD_WIDTH, 16, bits per channel word; must match the receiver's WORD_WIDTH.
DEPTH_LOG2, 3, FIFO depth is 2**DEPTH_LOG2 frames (default 8).

Ports:
clk_i  in  1  system clock; same clock as the receiver.
rst_ni  in  1  reset, asynchronous, active-low.
data_i  in  WORD_WIDTH  received word from the receiver's data_o.
lr_chnl_i  in  1  channel of data_i: 0 = left, 1 = right.
write_i  in  1  single-cycle strobe qualifying data_i and lr_chnl_i.
frame_o  out  2*WORD_WIDTH  head frame: left in [2W-1:W], right in [W-1:0].
valid_o  out  1  FIFO not empty; frame_o is valid.
ready_i  in  1  consumer accepts frame_o when valid_o & ready_i.
level_o  out  DEPTH_LOG2+1  number of frames stored, 0..2**DEPTH_LOG2.
ovf_o  out  1  sticky: a completed frame was dropped because the FIFO was full.
desync_o  out  1  sticky: channel-order violation detected.
clr_err_i  in  1  synchronous clear of ovf_o and desync_o.

Behaviour:
- Reset (rst_ni = 0, asynchronous): pairing FSM goes to WAIT_L; left holding register = 0; FIFO pointers = 0; valid_o = 0, level_o = 0, ovf_o = 0, desync_o = 0. frame_o reflects RAM[0] and its contents are don't-care.
- Pairing FSM has states WAIT_L and HAVE_L. Inputs are acted on only in cycles where write_i = 1.
  - WAIT_L, lr = 0: store data_i in the left holding register; go to HAVE_L.
  - WAIT_L, lr = 1: discard the orphan right word; set desync_o; stay in WAIT_L.
  - HAVE_L, lr = 0: overwrite the left holding register with the new word; set desync_o; stay in HAVE_L.
  - HAVE_L, lr = 1: form the frame {held left, data_i}; request a push; go to WAIT_L.
- Push is performed in the same cycle as the right-word strobe. The frame is visible at frame_o no earlier than the next cycle. Latency from the right-word write_i to valid_o is 1 cycle when the FIFO was empty.
- Pop: on valid_o & ready_i, advance the read pointer. frame_o is combinational from the RAM at the read pointer, so the frame is shown without a read bubble.
- Simultaneous push and pop:
  - Both occur; level_o is unchanged.
  - When the FIFO is full, a push in the same cycle as a pop is accepted and ovf_o is not set.
- Overflow: push while full with no pop. The frame is discarded, ovf_o is set, FIFO contents and pointers are unchanged, and the FSM still returns to WAIT_L.
- Empty: when valid_o = 0, ready_i is ignored and no pointer moves.
- Pointers are DEPTH_LOG2+1 bits with the wrap bit.
  - full when the low bits are equal and the MSBs differ.
  - empty when the pointers are equal.
  - level_o = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1).
- Sticky flags:
  - clr_err_i clears both flags next edge.
  - If a set event and clr_err_i occur in the same cycle, set wins.
- Reset asserted mid-frame or mid-transfer drops the held left word and all buffered frames immediately, with no partial output.
- No combinational path from write_i to valid_o. The ready_i to valid_o path is registered through the pointers.

Test Plan:
- Basic pair: write L=16'hA5A5 then R=16'h5A5A with ready_i = 0 -> one cycle later valid_o = 1, frame_o = 32'hA5A55A5A, level_o = 1; raise ready_i -> valid_o = 0 next cycle.
- Fill and overflow: 9 L/R pairs with values 16'h0001..16'h0012, ready_i = 0 -> level_o = 8, the 9th frame is dropped, ovf_o = 1; draining returns frames 1..8 in order.
- Full with simultaneous push/pop: FIFO full, ready_i = 1 in the same cycle as the right strobe -> level_o stays 8, ovf_o stays 0, the new frame is last out.
- Desync: R=16'h1111 first, then L=16'h2222, L=16'h3333, R=16'h4444 -> desync_o = 1, a single frame 32'h33334444; clr_err_i -> desync_o = 0.
- Async reset: with 3 frames buffered and the FSM in HAVE_L, pulse rst_ni low for 5 ns between clock edges -> valid_o = 0, level_o = 0, flags = 0 immediately; the next L/R pair produces a correct frame.
- Drive from the receiver: connect to the receiver top and stream 10 serial words (5 stereo pairs) -> 5 frames out, matching the transmitted L/R pairs bit-exactly.
